s_array_shuffle: RTL and testbench
==================================

# s_array_shuffle

RC4 key-scheduling stage that permutes the 256-byte S array in place using the 24-bit secret key. It sits directly downstream of `s_array_init`: after initialisation finishes (S[i]=i), the top-level pulses `start` and this block performs the 256 KSA swap iterations through the single S-RAM port. It then raises `finish` for the decryption stage that follows.

## Interface
- `KEY_BYTES`, 3: key length in bytes; key byte k = `secret_key[8*(KEY_BYTES-1-k) +: 8]`, so byte 0 is the MSB.
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; sampled only in IDLE and DONE.
- `secret_key`  in  24  key; must be stable from `start` until `finish`.
- `q`  in  8  S-RAM read data; valid the cycle after the address is presented.
- `array_address`  out  8  S-RAM address.
- `data`  out  8  S-RAM write data.
- `write_enable`  out  1  S-RAM write strobe.
- `busy`  out  1  high in every state except IDLE and DONE.
- `finish`  out  1  high in DONE and held until the next `start` or reset.

## Operation
- Registers: `i` (8 b), `j` (8 b), `k` (key index, 0..KEY_BYTES-1), `si` (8 b), `sj` (8 b), state.
- All outputs are registered or decoded from the state register. There is no combinational path from any input to any output.
- States:
  - IDLE: outputs 0. On `start`, clear i, j and k, then go to RD_I.
  - RD_I: `array_address`=i, `write_enable`=0. Go to WT_I.
  - WT_I: capture `si`=q. Set j ← j + q + key[k] (mod 256). Go to RD_J.
  - RD_J: `array_address`=j. Go to WT_J.
  - WT_J: capture `sj`=q. Go to WR_I.
  - WR_I: `array_address`=i, `data`=sj, `write_enable`=1. Go to WR_J.
  - WR_J: `array_address`=j, `data`=si, `write_enable`=1. If i==255, go to DONE. Otherwise i ← i+1, k ← (k==KEY_BYTES-1) ? 0 : k+1, and go to RD_I.
  - DONE: `finish`=1 and `write_enable`=0. On `start`, re-enter RD_I with i, j and k cleared.
- All arithmetic is 8-bit and wraps. Carries are discarded.
- i==j: both writes go to the same address with the same value. No special casing is needed, and the result is a no-op swap.
- `start` while busy is ignored. It does not restart or queue.
- Reset asserted mid-operation: all registers and outputs are cleared immediately, the block returns to IDLE, and no further writes occur. S contents are then undefined, so a full re-init is required.
- Reset values: `array_address`=0, `data`=0, `write_enable`=0, `busy`=0, `finish`=0, state=IDLE.

## Timing
- Each iteration takes 6 cycles (RD_I, WT_I, RD_J, WT_J, WR_I, WR_J). There are exactly 2 write cycles per iteration.
- `start` is sampled at edge E0, putting the block in RD_I during cycle E0→E0+1.
- DONE is entered at edge E0+1536, when `finish` rises and `busy` falls.
- 512 write strobes occur per run. `write_enable` is never high for two consecutive cycles at the same address except in the i==j case.
- RAM read latency is exactly 1 cycle: the address is registered by the RAM at the end of RD_x, and `q` is sampled at the end of WT_x.

## Test plan
- Key 24'h010203, identity S:
  - First write pairs are (addr 0, data 1), (1, 0); then (1, 3), (3, 0); then (2, 8), (8, 2).
  - Final 256-byte array matches a software KSA model.
- Key 24'h000000, identity S:
  - Iteration 0 writes address 0 with data 0 twice (i==j).
  - Final array matches the model.
- Timing and write count: pulse `start` → `finish`=1 exactly 1536 cycles after the sampling edge. `busy` is high throughout, and exactly 512 `write_enable` cycles are counted.
- `start` pulsed at cycle 100 of a run → no restart. `finish` still rises at 1536, and the array matches the model.
- `reset_n` dropped at cycle 700 → outputs are 0 in the same cycle and the block is in IDLE. After re-init and `start`, the run completes with a correct array.
- Key-index wrap:
  - Key 24'hFFFFFF drives j wrap on the first iterations: i=0 gives j=0xFF; i=1 gives j=(0xFF+1+0xFF)&0xFF=0xFF.
  - Final array matches the model.

Source files
------------

// File: rtl/s_array_shuffle.sv
// -----------------------------------------------------------------------------
// s_array_shuffle
//
// RC4 key-scheduling stage. Permutes a 256-byte S array, held in an external
// single-port RAM, in place using the secret key. It runs once per start pulse
// and expects S to have been initialised to S[i]=i beforehand.
//
// Each KSA iteration is a six-state read/read/write/write sequence through the
// one RAM port:
//   RD_I -> WT_I -> RD_J -> WT_J -> WR_I -> WR_J
// A run therefore takes 256 * 6 = 1536 cycles and issues 512 write strobes.
//
// Parameters
//   KEY_BYTES     number of key bytes; byte 0 is the most significant byte
//                 of secret_key.
//
// Ports
//   clk           sole clock, rising edge
//   reset_n       asynchronous active-low reset
//   start         single-cycle request, honoured only in IDLE and DONE
//   secret_key    key, must stay stable from start until finish
//   q             RAM read data, valid the cycle after the address
//   array_address RAM address (registered)
//   data          RAM write data (registered)
//   write_enable  RAM write strobe (registered)
//   busy          high while the shuffle is in progress
//   finish        high in DONE, held until the next start or reset
// -----------------------------------------------------------------------------
module s_array_shuffle #(
  parameter int unsigned KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [7:0]             q,
  output logic [7:0]             array_address,
  output logic [7:0]             data,
  output logic                   write_enable,
  output logic                   busy,
  output logic                   finish
);

  localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_I,
    S_WT_I,
    S_RD_J,
    S_WT_J,
    S_WR_I,
    S_WR_J,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [7:0]      r_i;
  logic [7:0]      r_j;
  logic [KW-1:0]   r_k;
  logic [7:0]      r_si;

  logic [7:0]      w_key_byte;
  logic [7:0]      w_j_next;
  logic [7:0]      w_i_next;
  logic [KW-1:0]   w_k_next;

  // Select key byte k; byte 0 sits in the top bits of secret_key.
  always_comb begin
    w_key_byte = '0;
    for (int unsigned b = 0; b < KEY_BYTES; b++) begin
      if (r_k == KW'(b)) begin
        w_key_byte = secret_key[8*(KEY_BYTES-1-b) +: 8];
      end
    end
  end

  // j + S[i] + key[k], all modulo 256 (carries dropped by the 8-bit result).
  assign w_j_next = r_j + q + w_key_byte;
  assign w_i_next = r_i + 8'd1;
  assign w_k_next = (r_k == KW'(KEY_BYTES-1)) ? '0 : r_k + KW'(1);

  // Outputs are loaded on the edge that enters the state they belong to, so
  // the RAM sees each address/strobe for exactly the cycle of that state.
  // The data register doubles as the S[j] holding register: S[j] is only
  // needed as write data in WR_I, so it is loaded straight from q in WT_J.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_i           <= '0;
      r_j           <= '0;
      r_k           <= '0;
      r_si          <= '0;
      array_address <= '0;
      data          <= '0;
      write_enable  <= 1'b0;
      busy          <= 1'b0;
      finish        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_i           <= '0;
            r_j           <= '0;
            r_k           <= '0;
            array_address <= '0;
            data          <= '0;
            write_enable  <= 1'b0;
            busy          <= 1'b1;
            finish        <= 1'b0;
            r_state       <= S_RD_I;
          end
        end

        S_RD_I: begin
          r_state <= S_WT_I;
        end

        S_WT_I: begin
          r_si          <= q;
          r_j           <= w_j_next;
          array_address <= w_j_next;
          r_state       <= S_RD_J;
        end

        S_RD_J: begin
          r_state <= S_WT_J;
        end

        S_WT_J: begin
          array_address <= r_i;
          data          <= q;
          write_enable  <= 1'b1;
          r_state       <= S_WR_I;
        end

        S_WR_I: begin
          array_address <= r_j;
          data          <= r_si;
          write_enable  <= 1'b1;
          r_state       <= S_WR_J;
        end

        S_WR_J: begin
          write_enable <= 1'b0;
          if (r_i == 8'hFF) begin
            array_address <= '0;
            data          <= '0;
            busy          <= 1'b0;
            finish        <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_i           <= w_i_next;
            r_k           <= w_k_next;
            array_address <= w_i_next;
            r_state       <= S_RD_I;
          end
        end

        default: begin
          array_address <= '0;
          data          <= '0;
          write_enable  <= 1'b0;
          busy          <= 1'b0;
          finish        <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s_array_shuffle.sv
module tb_s_array_shuffle;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  q;
  logic [7:0]  array_address;
  logic [7:0]  data;
  logic        write_enable;
  logic        busy;
  logic        finish;

  int unsigned n_tests;
  int unsigned n_fail;

  // S-RAM model: registered read address, write-first not needed.
  logic [7:0] mem [256];
  logic       init_req;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        sb [$];
  logic [7:0] mdl [256];
  logic [7:0] fa [6];
  logic [7:0] fd [6];

  s_array_shuffle #(.KEY_BYTES(3)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .secret_key    (secret_key),
    .q             (q),
    .array_address (array_address),
    .data          (data),
    .write_enable  (write_enable),
    .busy          (busy),
    .finish        (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (init_req) begin
      for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
    end else if (write_enable) begin
      mem[array_address] <= data;
    end
    q <= mem[array_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Software KSA: fills the scoreboard with every expected write and the
  // final array.
  task automatic build_model(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] j;
    logic [7:0] kb;
    logic [7:0] t;
    sb.delete();
    for (int a = 0; a < 256; a++) s[a] = 8'(a);
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      case (i % 3)
        0:       kb = key[23:16];
        1:       kb = key[15:8];
        default: kb = key[7:0];
      endcase
      j = j + s[i] + kb;
      sb.push_back('{a: 8'(i), d: s[j]});
      sb.push_back('{a: j,     d: s[i]});
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int a = 0; a < 256; a++) mdl[a] = s[a];
  endtask

  // mode 0: plain run, 1: extra start at cycle 100, 2: reset at cycle 700
  task automatic run(input logic [23:0] key, input int mode, input string nm);
    int  fin;
    int  nw;
    int  busy_bad;
    int  arr_bad;
    wr_t w;
    @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    build_model(key);
    secret_key = key;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    fin = -1;
    nw = 0;
    busy_bad = 0;
    for (int n = 0; n < 2000; n++) begin
      if (finish) begin
        fin = n;
        break;
      end
      if (!busy) busy_bad++;
      if (write_enable) begin
        if (sb.size() == 0) begin
          check({nm, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
          w = sb.pop_front();
          check({nm, "_wr_addr"}, 32'(array_address), 32'(w.a));
          check({nm, "_wr_data"}, 32'(data), 32'(w.d));
        end
        if (nw < 6) begin
          fa[nw] = array_address;
          fd[nw] = data;
        end
        nw++;
      end
      if (mode == 1 && n == 99)  start = 1'b1;
      if (mode == 1 && n == 100) start = 1'b0;
      if (mode == 2 && n == 700) begin
        reset_n = 1'b0;
        #1;
        check({nm, "_rst_addr"},   32'(array_address), 32'd0);
        check({nm, "_rst_data"},   32'(data),          32'd0);
        check({nm, "_rst_we"},     32'(write_enable),  32'd0);
        check({nm, "_rst_busy"},   32'(busy),          32'd0);
        check({nm, "_rst_finish"}, 32'(finish),        32'd0);
        @(negedge clk);
        check({nm, "_rst_hold_we"}, 32'(write_enable), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check({nm, "_idle_busy"}, 32'(busy), 32'd0);
        return;
      end
      @(posedge clk);
      #1;
    end
    check({nm, "_finish_cycle"}, 32'(fin), 32'd1536);
    check({nm, "_busy_in_run"},  32'(busy_bad), 32'd0);
    check({nm, "_we_count"},     32'(nw), 32'd512);
    check({nm, "_busy_done"},    32'(busy), 32'd0);
    check({nm, "_sb_left"},      32'(sb.size()), 32'd0);
    arr_bad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== mdl[a]) arr_bad++;
    check({nm, "_array"}, 32'(arr_bad), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check({nm, "_finish_held"}, 32'(finish), 32'd1);
    check({nm, "_we_done"},     32'(write_enable), 32'd0);
  endtask

  initial begin
    logic [7:0] ea [6];
    logic [7:0] ed [6];
    n_tests    = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    start      = 1'b0;
    secret_key = '0;
    init_req   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_addr",   32'(array_address), 32'd0);
    check("reset_data",   32'(data),          32'd0);
    check("reset_we",     32'(write_enable),  32'd0);
    check("reset_busy",   32'(busy),          32'd0);
    check("reset_finish", 32'(finish),        32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);

    run(24'h010203, 0, "k010203");
    ea = '{8'h00, 8'h01, 8'h01, 8'h03, 8'h02, 8'h08};
    ed = '{8'h01, 8'h00, 8'h03, 8'h00, 8'h08, 8'h02};
    for (int m = 0; m < 6; m++) begin
      check($sformatf("k010203_first_a%0d", m), 32'(fa[m]), 32'(ea[m]));
      check($sformatf("k010203_first_d%0d", m), 32'(fd[m]), 32'(ed[m]));
    end

    run(24'h000000, 0, "k000000");
    ea = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00};
    ed = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00};
    for (int m = 0; m < 4; m++) begin
      check($sformatf("k000000_first_a%0d", m), 32'(fa[m]), 32'(ea[m]));
      check($sformatf("k000000_first_d%0d", m), 32'(fd[m]), 32'(ed[m]));
    end

    run(24'hFFFFFF, 0, "kFFFFFF");
    ea = '{8'h00, 8'hFF, 8'h01, 8'hFF, 8'h00, 8'h00};
    ed = '{8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
    for (int m = 0; m < 4; m++) begin
      check($sformatf("kFFFFFF_first_a%0d", m), 32'(fa[m]), 32'(ea[m]));
      check($sformatf("kFFFFFF_first_d%0d", m), 32'(fd[m]), 32'(ed[m]));
    end

    run(24'h0A1B2C, 1, "midstart");
    run(24'h123456, 2, "rstmid");
    run(24'h123456, 0, "afterrst");
    run(24'($urandom), 0, "random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
